accu_half_diff: RTL and testbench
=================================

Name: accu_half_diff

Overview:
- Half-precision first-difference engine; the decoder counterpart of the running-sum accumulator.
- Takes a stream of running totals in IEEE-754 binary16 and, for each sample, outputs the difference from the previous sample in the same segment.
- Segments are delimited by a start flag.
- Internal arithmetic is 20-bit signed fixed point with 11 fractional bits, using the codebase Float2Fixed/Fixed2Float converters (FIXEDSIZE 20, FLOATSIZE 16, MANTISSABITS 10, EXPONENTBITS 5).
- Sits downstream of an accumulator or link to recover the original sample stream; valid/ready on both sides.

Parameters:
- FIXEDSIZE, 20, width of the internal fixed-point datapath.
- RADIX, 11, number of fractional bits passed as InRadixPoint to both converters.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample present.
- in_ready  out  1  block can accept a sample this cycle.
- n  in  1  first sample of a new segment; qualified by in_valid.
- x  in  16  binary16 running-total sample.
- out_valid  out  1  r is valid.
- out_ready  in  1  downstream accepts r.
- r  out  16  binary16 difference.
- out_first  out  1  r belongs to the first sample of a segment.
- err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset: out_valid=0, r=0, out_first=0, err=0, all pipeline valids=0, prev=0, state=IDLE.
- Reset asserted mid-stream discards all in-flight samples.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - in_ready = !(out_valid && !out_ready), i.e. the whole pipeline stalls only while the output is held.
  - r, out_first and out_valid stay stable while stalled.
- Pipeline, 3 stages, each with its own valid bit; all advance together when not stalled:
  - S1: register Float2Fixed(x), n, and converter overflow/exception.
  - S2: compute d = fx - prev, where prev is forced to 0 when the sample is a segment start. Then set prev <= fx.
  - S3: register Fixed2Float(d) into r, plus out_first.
- Latency: a sample accepted in cycle t gives out_valid in cycle t+3 when there is no backpressure. Throughput is 1 sample per cycle.
- Segment FSM, evaluated at S2 on a valid sample:
  - IDLE, n=1 -> RUN; treated as a start.
  - IDLE, n=0 -> RUN; treated as a start, and err is set (orphan segment).
  - RUN, n=1 -> RUN; restarts with prev forced to 0.
  - RUN, n=0 -> RUN; normal difference.
- Arithmetic:
  - d is computed at FIXEDSIZE+1 bits, then reduced to FIXEDSIZE bits (saturation or wrap; see Optional Feature).
  - A converter overflow or exception (|x| >= 256, NaN, Inf) sets err. The converter output is used as-is.
- Bubbles (no in_valid) do not change prev or the FSM state.
- Simultaneous accept and stall release is allowed: in_ready follows the out_ready of the same cycle.

Optional Feature:
- Macro: ACCU_HALF_DIFF_SAT_EN.
- Defined:
  - An out-of-range d clamps to +(2^19-1) or -2^19.
  - Any clamp event sets err.
- Undefined:
  - d wraps (two's complement truncation to 20 bits).
  - Wrap does not set err.

Test Plan:
- Basic differencing: with out_ready=1, send 0x3C00 (n=1), 0x4200, 0x4500 on consecutive cycles.
  - Required response: r = 0x3C00, 0x4000, 0x4000 at cycles t+3, t+4, t+5.
  - out_first = 1, 0, 0; err=0.
- Negative difference: send 0x4500 (n=1), then 0x4480.
  - Required response: r = 0x4500, 0xB800.
- Segment restart: send 0x4200 (n=1), 0x4500, 0x3C00 (n=1), 0x4000.
  - Required response: r = 0x4200, 0x4000, 0x3C00, 0x3C00.
  - out_first = 1, 0, 1, 0.
- Backpressure: hold out_ready=0 for 4 cycles while the first result is valid.
  - Required response: r held constant, in_ready=0.
  - All outputs are delivered in order with none lost or duplicated once out_ready=1.
- Overflow: send 0x5A40 (n=1), then 0xDA40.
  - With ACCU_HALF_DIFF_SAT_EN: second r = 0xDC00, err=1.
  - Without ACCU_HALF_DIFF_SAT_EN: second r = 0x5700, err=0.
- Error paths:
  - First sample after reset sent with n=0 -> err=1, r equals the input value.
  - Asserting reset mid-stream -> out_valid=0 and err=0 on the next cycle.

Source files
------------

// File: rtl/accu_half_diff.sv
// -----------------------------------------------------------------------------
// accu_half_diff
//   Half-precision first-difference engine. Takes a stream of binary16 running
//   totals and, for every sample, emits the difference from the previous sample
//   of the same segment (the inverse of a running-sum accumulator).
//
//   Internal arithmetic is FIXEDSIZE-bit signed fixed point with RADIX
//   fractional bits. Conversions use the float2fixed / fixed2float helpers
//   defined at the top of this file.
//
//   Optional build macro ACCU_HALF_DIFF_SAT_EN:
//     defined   : an out-of-range difference clamps to the fixed-point
//                 extremes and sets err.
//     undefined : the difference wraps (two's complement truncation) and
//                 does not touch err.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   in_valid   in   input sample present
//   in_ready   out  block can accept a sample this cycle
//   n          in   first sample of a new segment (qualified by in_valid)
//   x          in   binary16 running-total sample
//   out_valid  out  r is valid
//   out_ready  in   downstream accepts r
//   r          out  binary16 difference
//   out_first  out  r belongs to the first sample of a segment
//   err        out  sticky error flag, cleared only by reset
//   dbg_state  out  segment FSM state (0 = IDLE, 1 = RUN)
// -----------------------------------------------------------------------------

// binary16 -> signed fixed point. Out-of-range magnitudes and infinities
// saturate, NaN gives zero; overflow/exception report those cases.
module float2fixed #(
   parameter int FIXEDSIZE = 20
) (
   input  logic [15:0]          f,
   input  logic [4:0]           in_radix_point,
   output logic [FIXEDSIZE-1:0] q,
   output logic                 overflow,
   output logic                 exception
);
   localparam logic [FIXEDSIZE-1:0] FX_MAX = {1'b0, {(FIXEDSIZE-1){1'b1}}};
   localparam logic [FIXEDSIZE-1:0] FX_MIN = {1'b1, {(FIXEDSIZE-1){1'b0}}};

   logic [10:0]          sig;
   int                   sh;
   logic [63:0]          wide;
   logic [FIXEDSIZE-1:0] mag;

   always_comb begin
      exception = (f[14:10] == 5'h1f);
      sig       = (f[14:10] == 5'd0) ? {1'b0, f[9:0]} : {1'b1, f[9:0]};
      // sig carries 10 fraction bits; subnormals use an effective exponent
      // of 1. Net shift = unbiased exponent + radix - 10.
      sh   = ((f[14:10] == 5'd0) ? 1 : int'(f[14:10])) + int'(in_radix_point) - 25;
      wide = {53'd0, sig};
      if (sh >= 0) wide = wide << sh;
      else         wide = wide >> (-sh);
      overflow = !exception && (wide[63:FIXEDSIZE-1] != '0);
      mag      = wide[FIXEDSIZE-1:0];
      if (exception)     q = (f[9:0] != 10'd0) ? '0 : (f[15] ? FX_MIN : FX_MAX);
      else if (overflow) q = f[15] ? FX_MIN : FX_MAX;
      else               q = f[15] ? -mag : mag;
   end
endmodule

// signed fixed point -> binary16. Mantissa is truncated; results beyond the
// binary16 exponent range become infinity or flush to zero.
module fixed2float #(
   parameter int FIXEDSIZE = 20
) (
   input  logic [FIXEDSIZE-1:0] q,
   input  logic [4:0]           in_radix_point,
   output logic [15:0]          f
);
   logic [FIXEDSIZE-1:0] mag;
   int                   p;
   int                   e_b;
   logic [9:0]           mant;

   always_comb begin
      // -MIN wraps to MIN, which read as unsigned is the right magnitude.
      mag = q[FIXEDSIZE-1] ? -q : q;
      p   = 0;
      for (int i = 0; i < FIXEDSIZE; i++) begin
         if (mag[i]) p = i;
      end
      e_b = p - int'(in_radix_point) + 15;
      // Bring the leading one to bit 10; the 10-bit cast drops it.
      if (p >= 10) mant = 10'(mag >> (p - 10));
      else         mant = 10'(mag << (10 - p));
      if (mag == '0)     f = 16'h0000;
      else if (e_b >= 31) f = {q[FIXEDSIZE-1], 5'h1f, 10'h000};
      else if (e_b <= 0)  f = {q[FIXEDSIZE-1], 15'h0000};
      else                f = {q[FIXEDSIZE-1], 5'(e_b), mant};
   end
endmodule

module accu_half_diff #(
   parameter int FIXEDSIZE = 20,
   parameter int RADIX     = 11
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        n,
   input  logic [15:0] x,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] r,
   output logic        out_first,
   output logic        err,
   output logic        dbg_state
);
`ifdef ACCU_HALF_DIFF_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   localparam logic [4:0]           RADIX_PT = 5'(RADIX);
   localparam logic [FIXEDSIZE-1:0] FX_MAX   = {1'b0, {(FIXEDSIZE-1){1'b1}}};
   localparam logic [FIXEDSIZE-1:0] FX_MIN   = {1'b1, {(FIXEDSIZE-1){1'b0}}};

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t state_q, state_d;

   // Handshake: a sample transfers on in_valid && in_ready, a result on
   // out_valid && out_ready. The whole pipeline moves as one unit and only
   // stalls while a valid result is held at the output, so in_ready follows
   // out_ready combinationally within the same cycle.
   logic stall, adv;

   // Stage 1
   logic                 s1_valid, s1_n, s1_cerr;
   logic [FIXEDSIZE-1:0] s1_fx;
   // Stage 2
   logic                 s2_valid, s2_first;
   logic [FIXEDSIZE-1:0] s2_d;
   logic [FIXEDSIZE-1:0] prev_q;

   logic [FIXEDSIZE-1:0] fx_c;
   logic                 cv_ovf, cv_exc;
   logic [15:0]          r_c;

   logic                 seg_start, orphan, d_ovf, err_set;
   logic [FIXEDSIZE-1:0] prev_eff, d_red;
   logic [FIXEDSIZE:0]   d_full;

   float2fixed #(.FIXEDSIZE(FIXEDSIZE)) u_f2x (
      .f              (x),
      .in_radix_point (RADIX_PT),
      .q              (fx_c),
      .overflow       (cv_ovf),
      .exception      (cv_exc)
   );

   fixed2float #(.FIXEDSIZE(FIXEDSIZE)) u_x2f (
      .q              (s2_d),
      .in_radix_point (RADIX_PT),
      .f              (r_c)
   );

   assign stall     = out_valid && !out_ready;
   assign adv       = !stall;
   assign in_ready  = adv;
   assign dbg_state = state_q;

   // Segment FSM next state plus the stage-2 difference.
   always_comb begin
      state_d   = state_q;
      seg_start = 1'b0;
      orphan    = 1'b0;
      if (s1_valid) begin
         case (state_q)
            IDLE: begin
               state_d   = RUN;
               seg_start = 1'b1;
               orphan    = !s1_n;   // segment began without a start flag
            end
            RUN: begin
               seg_start = s1_n;
            end
            default: state_d = IDLE;
         endcase
      end
      prev_eff = seg_start ? '0 : prev_q;
      d_full   = {s1_fx[FIXEDSIZE-1], s1_fx} - {prev_eff[FIXEDSIZE-1], prev_eff};
      d_ovf    = (d_full[FIXEDSIZE] != d_full[FIXEDSIZE-1]);
      d_red    = d_full[FIXEDSIZE-1:0];
      if (SAT_EN && d_ovf) d_red = d_full[FIXEDSIZE] ? FX_MIN : FX_MAX;
      err_set  = s1_valid && (orphan || s1_cerr || (SAT_EN && d_ovf));
   end

   always_ff @(posedge clock) begin
      if (reset)    state_q <= IDLE;
      else if (adv) state_q <= state_d;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid  <= 1'b0;
         s1_n      <= 1'b0;
         s1_cerr   <= 1'b0;
         s1_fx     <= '0;
         s2_valid  <= 1'b0;
         s2_first  <= 1'b0;
         s2_d      <= '0;
         prev_q    <= '0;
         out_valid <= 1'b0;
         r         <= 16'h0000;
         out_first <= 1'b0;
         err       <= 1'b0;
      end else if (adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_fx   <= fx_c;
            s1_n    <= n;
            s1_cerr <= cv_ovf || cv_exc;
         end
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_d     <= d_red;
            s2_first <= seg_start;
            prev_q   <= s1_fx;
         end
         err       <= err || err_set;
         out_valid <= s2_valid;
         if (s2_valid) begin
            r         <= r_c;
            out_first <= s2_first;
         end
      end
   end
endmodule

// File: tb/tb_accu_half_diff.sv
// -----------------------------------------------------------------------------
// tb_accu_half_diff
//   Directed bench for accu_half_diff. Inputs change 1 time unit after the
//   rising edge and outputs are checked at that same point, well away from
//   the next edge. Expected values are hand-computed binary16 constants.
// -----------------------------------------------------------------------------
module tb_accu_half_diff;
`ifdef ACCU_HALF_DIFF_SAT_EN
   localparam logic [15:0] EXP_OV_R   = 16'hDC00;
   localparam logic [15:0] EXP_OV_ERR = 16'd1;
`else
   localparam logic [15:0] EXP_OV_R   = 16'h5700;
   localparam logic [15:0] EXP_OV_ERR = 16'd0;
`endif

   // clock / reset
   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, n;
   logic [15:0] x;
   logic        out_valid, out_ready, out_first, err, dbg_state;
   logic [15:0] r;

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] exp_q[$];
   logic [15:0] got_q[$];

   always #5 clock = ~clock;

   accu_half_diff dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .n         (n),
      .x         (x),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .r         (r),
      .out_first (out_first),
      .err       (err),
      .dbg_state (dbg_state)
   );

   // driver tasks
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic first, input logic [15:0] val);
      in_valid = 1'b1;
      n        = first;
      x        = val;
      tick();
      in_valid = 1'b0;
      n        = 1'b0;
      x        = 16'h0000;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      n         = 1'b0;
      x         = 16'h0000;
      out_ready = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      // reset state
      chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
      chk("rst_r",         r,                  16'h0000);
      chk("rst_out_first", {15'd0, out_first}, 16'd0);
      chk("rst_err",       {15'd0, err},       16'd0);
      chk("rst_in_ready",  {15'd0, in_ready},  16'd1);
      chk("rst_state",     {15'd0, dbg_state}, 16'd0);

      // basic differencing: 1.0, 3.0, 5.0 -> 1.0, 2.0, 2.0
      send(1'b1, 16'h3C00);
      chk("basic_lat1", {15'd0, out_valid}, 16'd0);
      send(1'b0, 16'h4200);
      chk("basic_lat2", {15'd0, out_valid}, 16'd0);
      send(1'b0, 16'h4500);
      chk("basic_v0",   {15'd0, out_valid}, 16'd1);
      chk("basic_r0",   r,                  16'h3C00);
      chk("basic_f0",   {15'd0, out_first}, 16'd1);
      chk("basic_st",   {15'd0, dbg_state}, 16'd1);
      tick();
      chk("basic_r1",   r,                  16'h4000);
      chk("basic_f1",   {15'd0, out_first}, 16'd0);
      tick();
      chk("basic_r2",   r,                  16'h4000);
      chk("basic_f2",   {15'd0, out_first}, 16'd0);
      chk("basic_err",  {15'd0, err},       16'd0);
      tick();
      chk("basic_drain", {15'd0, out_valid}, 16'd0);

      // negative difference: 5.0, 4.5 -> 5.0, -0.5
      send(1'b1, 16'h4500);
      send(1'b0, 16'h4480);
      tick();
      chk("neg_r0", r,                  16'h4500);
      chk("neg_f0", {15'd0, out_first}, 16'd1);
      tick();
      chk("neg_r1", r,                  16'hB800);
      chk("neg_f1", {15'd0, out_first}, 16'd0);
      tick();

      // segment restart: 3, 5 | 1, 2 -> 3, 2, 1, 1
      send(1'b1, 16'h4200);
      send(1'b0, 16'h4500);
      send(1'b1, 16'h3C00);
      chk("rst_seg_r0", r,                  16'h4200);
      chk("rst_seg_f0", {15'd0, out_first}, 16'd1);
      send(1'b0, 16'h4000);
      chk("rst_seg_r1", r,                  16'h4000);
      chk("rst_seg_f1", {15'd0, out_first}, 16'd0);
      tick();
      chk("rst_seg_r2", r,                  16'h3C00);
      chk("rst_seg_f2", {15'd0, out_first}, 16'd1);
      tick();
      chk("rst_seg_r3", r,                  16'h3C00);
      chk("rst_seg_f3", {15'd0, out_first}, 16'd0);
      tick();

      // bubbles leave prev untouched: 1.0, (gap), 3.0 -> 1.0, 2.0
      send(1'b1, 16'h3C00);
      tick();
      tick();
      chk("bub_r0", r, 16'h3C00);
      send(1'b0, 16'h4200);
      chk("bub_gap", {15'd0, out_valid}, 16'd0);
      tick();
      tick();
      chk("bub_v1", {15'd0, out_valid}, 16'd1);
      chk("bub_r1", r,                  16'h4000);
      tick();
      tick();

      // backpressure: 1.0, 3.0, 3.5, 5.0 -> 1.0, 2.0, 0.5, 1.5
      exp_q = {16'h3C00, 16'h4000, 16'h3800, 16'h3E00};
      out_ready = 1'b0;
      send(1'b1, 16'h3C00);
      send(1'b0, 16'h4200);
      send(1'b0, 16'h4300);
      in_valid = 1'b1;
      n        = 1'b0;
      x        = 16'h4500;
      for (int i = 0; i < 4; i++) begin
         chk("bp_hold_v",   {15'd0, out_valid}, 16'd1);
         chk("bp_hold_r",   r,                  16'h3C00);
         chk("bp_in_ready", {15'd0, in_ready},  16'd0);
         tick();
      end
      out_ready = 1'b1;
      got_q.delete();
      for (int i = 0; i < 8; i++) begin
         if (out_valid && out_ready) got_q.push_back(r);
         tick();
         if (i == 0) begin
            in_valid = 1'b0;
            x        = 16'h0000;
         end
      end
      chk("bp_count", 16'(got_q.size()), 16'd4);
      for (int i = 0; i < 4; i++) begin
         chk("bp_order", (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]);
      end

      // overflow: 200, -200 -> 200, then -400 clamped or wrapped
      do_reset();
      send(1'b1, 16'h5A40);
      send(1'b0, 16'hDA40);
      tick();
      chk("ovf_r0",  r, 16'h5A40);
      tick();
      chk("ovf_r1",  r,                 EXP_OV_R);
      chk("ovf_err", {15'd0, err},      EXP_OV_ERR);
      tick();
      tick();

      // orphan segment after reset
      do_reset();
      chk("orph_err0", {15'd0, err},       16'd0);
      chk("orph_st0",  {15'd0, dbg_state}, 16'd0);
      send(1'b0, 16'h4200);
      tick();
      tick();
      chk("orph_v",    {15'd0, out_valid}, 16'd1);
      chk("orph_r",    r,                  16'h4200);
      chk("orph_f",    {15'd0, out_first}, 16'd1);
      chk("orph_err",  {15'd0, err},       16'd1);

      // reset mid-stream discards in-flight samples and clears err
      send(1'b1, 16'h3C00);
      send(1'b0, 16'h4000);
      reset = 1'b1;
      tick();
      chk("mid_v",   {15'd0, out_valid}, 16'd0);
      chk("mid_err", {15'd0, err},       16'd0);
      chk("mid_r",   r,                  16'h0000);
      chk("mid_f",   {15'd0, out_first}, 16'd0);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("mid_flush", {15'd0, out_valid}, 16'd0);
         tick();
      end

      // converter exception (infinity) sets the sticky err
      send(1'b1, 16'h7C00);
      tick();
      tick();
      chk("inf_err", {15'd0, err}, 16'd1);
      tick();
      tick();
      chk("inf_sticky", {15'd0, err}, 16'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
